mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the instruction-fetch requester (IF) and the load/store requester (LSU) of the RV32 core.
- Accepts one transaction at a time and drives the memory port for it.
- Counts the memory's fixed read latency and returns the response to whichever requester was granted.
- Default arbitration is fixed priority (LSU first) with a starvation guard for IF.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LSU arbiter for a shared single-port memory with fixed read latency.
// Optional ARB_ROUND_ROBIN_EN: alternate on ties instead of LSU-priority with IF starvation guard.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [XLEN/8-1:0] lsu_be_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      lat_cnt;
    logic            owner_lsu;
    logic            owner_we;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] lsu_rdata_q;
    logic            arb_pt;
    logic            pick_if;

`ifdef ARB_ROUND_ROBIN_EN
    logic            last_lsu;
    assign pick_if = last_lsu;
`else
    logic [3:0]      starve_cnt;
    assign pick_if = (starve_cnt == 4'(STARVE_MAX));
`endif

    // Grants are gated by reset so every output reads 0 while rstn_i is low.
    assign arb_pt    = rstn_i && (state == IDLE || state == RESP);
    assign if_gnt_o  = arb_pt && if_req_i && (!lsu_req_i || pick_if);
    assign lsu_gnt_o = arb_pt && lsu_req_i && !(if_req_i && pick_if);

    assign mem_req_o   = if_gnt_o || lsu_gnt_o;
    assign mem_we_o    = lsu_gnt_o && lsu_we_i;
    assign mem_be_o    = lsu_gnt_o ? lsu_be_i   : (if_gnt_o ? '1 : '0);
    assign mem_addr_o  = lsu_gnt_o ? lsu_addr_i : (if_gnt_o ? if_addr_i : '0);
    assign mem_wdata_o = lsu_gnt_o ? lsu_wdata_i : '0;

    assign if_rvalid_o  = rstn_i && (state == RESP) && !owner_lsu;
    assign lsu_rvalid_o = rstn_i && (state == RESP) && owner_lsu;
    assign if_rdata_o   = rstn_i ? if_rdata_q  : '0;
    assign lsu_rdata_o  = rstn_i ? lsu_rdata_q : '0;
    assign busy_o       = rstn_i && (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            owner_lsu   <= 1'b0;
            owner_we    <= 1'b0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu    <= 1'b0;
`else
            starve_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (mem_req_o) begin
                        owner_lsu <= lsu_gnt_o;
                        owner_we  <= mem_we_o;
                        lat_cnt   <= 4'(MEM_LAT - 1);
                        state     <= WAIT;
                    end else begin
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        // A write acknowledges with zero data rather than whatever the bus holds.
                        if (owner_lsu) lsu_rdata_q <= owner_we ? '0 : mem_rdata_i;
                        else           if_rdata_q  <= mem_rdata_i;
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            if (mem_req_o) last_lsu <= lsu_gnt_o;
`else
            if (arb_pt) begin
                if (if_gnt_o || !if_req_i) starve_cnt <= '0;
                else if (lsu_gnt_o)        starve_cnt <= starve_cnt + 4'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            lsu_req, lsu_we;
    logic [3:0]      lsu_be;
    logic [XLEN-1:0] lsu_addr, lsu_wdata;
    logic            lsu_gnt, lsu_rvalid;
    logic [XLEN-1:0] lsu_rdata;
    logic            mem_req, mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.XLEN(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Memory model: word at 0x10 is 0x00500093, others {addr[15:0],16'hA5A5}; bus shows junk otherwise.
    logic            p0_v = 1'b0, p1_v = 1'b0;
    logic [XLEN-1:0] p0_a = '0, p1_a = '0;
    always @(posedge clk) begin
        p0_v <= mem_req && !mem_we;
        p0_a <= mem_addr;
        p1_v <= p0_v;
        p1_a <= p0_a;
    end
    assign mem_rdata = !p1_v ? 32'hBAD0BAD0 :
                       (p1_a == 32'h10) ? 32'h00500093 : {p1_a[15:0], 16'hA5A5};

    logic [138:0] outs;
    assign outs = {if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
                   mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 0; if_addr = '0; lsu_req = 0; lsu_we = 0; lsu_be = '0;
        lsu_addr = '0; lsu_wdata = '0;
    endtask

    task automatic test_reset();
        rstn = 0;
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin if_req = 1; lsu_req = 1; lsu_addr = 32'h44; end
            #3;
            n_cmp++;
            if (outs !== '0) begin
                n_err++; $display("FAIL reset_outs cycle %0d: got %h want 0", c, outs);
            end
        end
        tick();
        rstn = 1;
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++;
            if (outs !== '0) begin
                n_err++; $display("FAIL post_reset_idle cycle %0d: got %h want 0", c, outs);
            end
            tick();
        end
    endtask

    task automatic test_if_read();
        if_req = 1; if_addr = 32'h10;
        #3;
        n_cmp++;
        if ({if_gnt, lsu_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0}) begin
            n_err++; $display("FAIL if_read_grant: gnt=%b mreq=%b we=%b be=%h addr=%h wd=%h want gnt=1 mreq=1 we=0 be=f addr=10 wd=0",
                              if_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        if_req = 0;
        for (int c = 1; c <= 4; c++) begin
            #3;
            n_cmp++;
            if (if_rvalid !== (c == 3)) begin
                n_err++; $display("FAIL if_read_rvalid cycle %0d: got %b want %b", c, if_rvalid, c == 3);
            end
            if (c == 3) begin
                n_cmp++;
                if (if_rdata !== 32'h00500093) begin
                    n_err++; $display("FAIL if_read_rdata: got %h want 00500093", if_rdata);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if ({busy, mem_req} !== 2'b10) begin
                    n_err++; $display("FAIL if_read_wait: busy/mem_req got %b want 10", {busy, mem_req});
                end
            end
            tick();
        end
    endtask

    task automatic test_tie_overlap();
        if_req = 1; if_addr = 32'h10;
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h40;
        for (int c = 0; c <= 7; c++) begin
            #3;
            n_cmp++;
            if ({lsu_gnt, if_gnt} !== {c == 0, c == 3}) begin
                n_err++; $display("FAIL tie_gnt cycle %0d: lsu/if got %b%b want %b%b", c, lsu_gnt, if_gnt, c == 0, c == 3);
            end
            n_cmp++;
            if ({lsu_rvalid, if_rvalid} !== {c == 3, c == 6}) begin
                n_err++; $display("FAIL tie_rvalid cycle %0d: lsu/if got %b%b want %b%b", c, lsu_rvalid, if_rvalid, c == 3, c == 6);
            end
            if (c == 3) begin
                n_cmp++;
                if ({lsu_rdata, mem_addr} !== {32'h0040A5A5, 32'h10}) begin
                    n_err++; $display("FAIL tie_overlap: lsu_rdata=%h mem_addr=%h want 0040a5a5 00000010", lsu_rdata, mem_addr);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (if_rdata !== 32'h00500093) begin
                    n_err++; $display("FAIL tie_if_rdata: got %h want 00500093", if_rdata);
                end
            end
            tick();
            if (c == 0) lsu_req = 0;
            if (c == 3) if_req = 0;
        end
    endtask

    task automatic test_lsu_write();
        lsu_req = 1; lsu_we = 1; lsu_be = 4'b0011; lsu_addr = 32'h200; lsu_wdata = 32'hDEADBEEF;
        #3;
        n_cmp++;
        if ({lsu_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_grant: gnt=%b mreq=%b we=%b be=%b addr=%h wd=%h want 1 1 1 0011 200 deadbeef",
                              lsu_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        lsu_req = 0;
        for (int c = 1; c <= 4; c++) begin
            #3;
            if (c == 1) begin
                n_cmp++;
                if ({mem_we, mem_be, mem_addr, mem_wdata, lsu_rdata} !== {1'b0, 4'h0, 32'h0, 32'h0, 32'h0040A5A5}) begin
                    n_err++; $display("FAIL wr_idle_bus: we=%b be=%h addr=%h wd=%h rdata=%h want 0 0 0 0 0040a5a5",
                                      mem_we, mem_be, mem_addr, mem_wdata, lsu_rdata);
                end
            end
            n_cmp++;
            if (lsu_rvalid !== (c == 3)) begin
                n_err++; $display("FAIL wr_rvalid cycle %0d: got %b want %b", c, lsu_rvalid, c == 3);
            end
            if (c == 3) begin
                n_cmp++;
                if (lsu_rdata !== 32'h0) begin
                    n_err++; $display("FAIL wr_rdata: got %h want 0", lsu_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        logic [7:0] got_who [6];
        int         got_cyc [6];
        logic [7:0] exp_who [6];
        int         ng;
        string      seq;
`ifdef ARB_ROUND_ROBIN_EN
        seq = "LILILI";
`else
        seq = "LLLLIL";
`endif
        for (int i = 0; i < 6; i++) exp_who[i] = seq[i];
        ng = 0;
        rstn = 0;
        drive_idle();
        tick();
        rstn = 1;
        if_req = 1; if_addr = 32'h14;
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h80;
        for (int c = 0; c < 16; c++) begin
            #3;
            if (lsu_gnt || if_gnt) begin
                if (ng < 6) begin
                    got_who[ng] = lsu_gnt ? 8'h4C : 8'h49;
                    got_cyc[ng] = c;
                end
                ng++;
            end
            n_cmp++;
            if ((lsu_gnt && if_gnt) !== 1'b0) begin
                n_err++; $display("FAIL starve_dual_gnt cycle %0d: both grants high", c);
            end
            tick();
        end
        drive_idle();
        n_cmp++;
        if (ng !== 6) begin
            n_err++; $display("FAIL starve_count: got %0d grants want 6", ng);
        end
        for (int i = 0; i < 6 && i < ng; i++) begin
            n_cmp++;
            if (got_who[i] !== exp_who[i] || got_cyc[i] !== 3 * i) begin
                n_err++; $display("FAIL starve_seq grant %0d: got %c@%0d want %c@%0d",
                                  i, got_who[i], got_cyc[i], exp_who[i], 3 * i);
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_txn();
        if_req = 1; if_addr = 32'h10;
        #3;
        n_cmp++;
        if (if_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_if_gnt: got %b want 1", if_gnt);
        end
        tick();
        if_req = 0;
        rstn = 0;
        #3;
        n_cmp++;
        if ({busy, mem_req, if_rvalid} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_in_reset: busy/mreq/rvalid got %b want 000", {busy, mem_req, if_rvalid});
        end
        tick();
        rstn = 1;
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h40;
        #3;
        n_cmp++;
        if ({lsu_gnt, mem_addr} !== {1'b1, 32'h40}) begin
            n_err++; $display("FAIL rst_mid_lsu_gnt: gnt=%b addr=%h want 1 40", lsu_gnt, mem_addr);
        end
        tick();
        lsu_req = 0;
        for (int c = 3; c <= 6; c++) begin
            #3;
            n_cmp++;
            if ({if_rvalid, lsu_rvalid} !== {1'b0, c == 5}) begin
                n_err++; $display("FAIL rst_mid_rvalid cycle %0d: if/lsu got %b%b want 0%b", c, if_rvalid, lsu_rvalid, c == 5);
            end
            if (c == 5) begin
                n_cmp++;
                if ({lsu_rdata, if_rdata} !== {32'h0040A5A5, 32'h0}) begin
                    n_err++; $display("FAIL rst_mid_rdata: lsu=%h if=%h want 0040a5a5 0", lsu_rdata, if_rdata);
                end
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_if_read();
        test_tie_overlap();
        test_lsu_write();
        test_starvation();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
